single_loop: RTL and testbench
==============================

# single_loop

Iteration tracker for one hardware loop level in the control unit's pre-queue loop logic. It captures a loop trip count and loop mode while held in reset, counts iterations each time the loop-end instruction takes its backward jump, and flags `done` when the current pass is the final one. Inner independent loops advance by the superscalar issue width per pass, so one pass covers 2^SUPERSCALAR_LOG_WIDTH iterations.

## Interface
- BITS, 18, width of iteration count and iteration index
- SUPERSCALAR_LOG_WIDTH, 2, log2 of issue width; step for independent loops = 2^SUPERSCALAR_LOG_WIDTH
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; also the configuration-load window
- should_increment  input  1  enables counting; jumps are ignored when 0
- initial_iteration_count  input  BITS  total trip count, sampled while reset asserted
- initial_is_inner_independent_loop  input  1  mode, sampled while reset asserted; 1 = step by issue width
- jumped  input  1  one-cycle pulse: loop-end instruction took the backward jump this cycle
- done  output  1  current pass is the last pass
- current_iteration  output  BITS  index of the first iteration of the current pass

## Operation
- State: `iter` (BITS), `limit` (BITS), `indep` (1).
- Reset asserted (reset=0): `iter` cleared to 0 asynchronously; `done` forced 0. On every rising edge while asserted, `limit`←initial_iteration_count and `indep`←initial_is_inner_independent_loop. Reset must be held across at least one rising edge to load configuration.
- Step: STEP = indep ? 2^SUPERSCALAR_LOG_WIDTH : 1.
- done = reset deasserted AND (iter + STEP ≥ limit), compared at BITS+1 bits so no wrap.
- Increment: on a rising edge with reset deasserted, should_increment=1, jumped=1 and done=0: iter←iter+STEP. Otherwise iter holds.
- Jump while done=1: ignored; iter saturates at last pass, done stays 1.
- should_increment=0: iter frozen regardless of jumped.
- current_iteration = iter.
- limit=0 or limit ≤ STEP: done=1 immediately after reset release (single pass).
- Non-multiple trip counts in independent mode: last pass is the one where iter+STEP ≥ limit (e.g. limit 13, step 4: passes 0,4,8,12).
- Configuration inputs are ignored while reset deasserted.

## Timing
- Reset values: current_iteration=0, done=0.
- done and current_iteration are combinational from registered state: valid in the cycle after the reset-release edge or the jump edge that changes `iter`.
- Jump latency: jumped sampled at edge N → current_iteration/done updated after edge N.
- Reset mid-operation: asserting reset immediately clears iter and done regardless of jumped; new configuration taken at the next edge while asserted.
- No back-pressure or handshake; jumped is a single-cycle qualifier, repeated pulses each count once per edge.

## Test plan
- Normal loop: load count=3, mode=0, release reset, should_increment=1; done=0, iter=0; jump → iter=1, done=0; jump → iter=2, done=1; further jump → iter stays 2, done=1.
- Independent loop: load count=12, mode=1 (step 4); done=0 at iter=0 and 4; done=1 at iter=8; extra jumps hold iter=8.
- Non-multiple: count=13, mode=1 → passes 0,4,8,12; done only at 12. Count=0 or 1 (either mode) → done=1 right after release.
- Gating: should_increment=0 with repeated jumped pulses → iter stays 0, done stays 0.
- Reset mid-loop: at iter=2/done=1 assert reset with jumped=1 → done=0 and current_iteration=0 immediately and while held; after release with count 3 mode 0 → done=0.
- Wide count: count=2^18−1, mode=0; jump many times near top → no wrap, done asserts exactly at iter=2^18−2.

Source files
------------

// File: rtl/single_loop.sv
// Iteration tracker for one hardware loop level: captures trip count and mode
// while held in reset, then advances once per taken backward jump until the last pass.
module single_loop #(
  parameter int BITS                  = 18,
  parameter int SUPERSCALAR_LOG_WIDTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            should_increment,
  input  logic [BITS-1:0] initial_iteration_count,
  input  logic            initial_is_inner_independent_loop,
  input  logic            jumped,
  output logic            done,
  output logic [BITS-1:0] current_iteration
);

  localparam logic [BITS:0] STEP_INDEP = (BITS+1)'(1) << SUPERSCALAR_LOG_WIDTH;
  localparam logic [BITS:0] STEP_ONE   = (BITS+1)'(1);

  logic [BITS-1:0] iter_q, iter_d;
  logic [BITS-1:0] limit_q;
  logic            indep_q;
  logic [BITS:0]   step;
  logic [BITS:0]   next_pass;
  logic            advance;

  // Configuration is captured on every edge of the reset window and frozen afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      limit_q <= initial_iteration_count;
      indep_q <= initial_is_inner_independent_loop;
    end
  end

  // The extra top bit keeps iter+step from wrapping when limit sits near 2^BITS.
  always_comb begin
    step      = indep_q ? STEP_INDEP : STEP_ONE;
    next_pass = {1'b0, iter_q} + step;
    done      = reset && (next_pass >= {1'b0, limit_q});
    advance   = should_increment && jumped && !done;
    iter_d    = iter_q;
    if (advance) begin
      iter_d = next_pass[BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter_q <= '0;
    end else begin
      iter_q <= iter_d;
    end
  end

  assign current_iteration = iter_q;

endmodule

// File: tb/tb_single_loop.sv
// Directed-vector bench for single_loop: a full-width instance plus a narrow
// instance that exercises the near-overflow comparison.
module tb_single_loop;

  localparam int BITS  = 18;
  localparam int WBITS = 4;

  logic             clk;
  logic             reset;
  logic             should_increment;
  logic [BITS-1:0]  init_count;
  logic             init_indep;
  logic             jumped;
  logic             done;
  logic [BITS-1:0]  cur_iter;

  logic             w_reset;
  logic             w_should_increment;
  logic [WBITS-1:0] w_init_count;
  logic             w_init_indep;
  logic             w_jumped;
  logic             w_done;
  logic [WBITS-1:0] w_cur_iter;

  int checks;
  int errors;

  single_loop #(.BITS(BITS), .SUPERSCALAR_LOG_WIDTH(2)) dut (
    .clk                               (clk),
    .reset                             (reset),
    .should_increment                  (should_increment),
    .initial_iteration_count           (init_count),
    .initial_is_inner_independent_loop (init_indep),
    .jumped                            (jumped),
    .done                              (done),
    .current_iteration                 (cur_iter)
  );

  single_loop #(.BITS(WBITS), .SUPERSCALAR_LOG_WIDTH(2)) dut_w (
    .clk                               (clk),
    .reset                             (w_reset),
    .should_increment                  (w_should_increment),
    .initial_iteration_count           (w_init_count),
    .initial_is_inner_independent_loop (w_init_indep),
    .jumped                            (w_jumped),
    .done                              (w_done),
    .current_iteration                 (w_cur_iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge with the given configuration, then release.
  task automatic load(input logic [BITS-1:0] cnt, input logic mode);
    reset      = 1'b0;
    init_count = cnt;
    init_indep = mode;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic jump_n(input int n);
    for (int i = 0; i < n; i++) begin
      jumped = 1'b1;
      tick();
      jumped = 1'b0;
    end
  endtask

  task automatic w_load(input logic [WBITS-1:0] cnt, input logic mode);
    w_reset      = 1'b0;
    w_init_count = cnt;
    w_init_indep = mode;
    tick();
    w_reset = 1'b1;
    #1;
  endtask

  task automatic w_jump_n(input int n);
    for (int i = 0; i < n; i++) begin
      w_jumped = 1'b1;
      tick();
      w_jumped = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; should_increment = 1'b1; init_count = '0; init_indep = 1'b0; jumped = 1'b0;
    w_reset = 1'b0; w_should_increment = 1'b1; w_init_count = '0; w_init_indep = 1'b0; w_jumped = 1'b0;

    // Reset state and normal loop, count 3 step 1
    init_count = 18'd3;
    tick();
    check("rst_iter", 32'(cur_iter), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b1;
    #1;
    check("norm_i0", 32'(cur_iter), 0);
    check("norm_d0", 32'(done), 0);
    jump_n(1);
    check("norm_i1", 32'(cur_iter), 1);
    check("norm_d1", 32'(done), 0);
    jump_n(1);
    check("norm_i2", 32'(cur_iter), 2);
    check("norm_d2", 32'(done), 1);
    jump_n(3);
    check("norm_sat_i", 32'(cur_iter), 2);
    check("norm_sat_d", 32'(done), 1);

    // Reset mid-loop with jumped held high
    jumped = 1'b1;
    reset  = 1'b0;
    #1;
    check("midrst_i", 32'(cur_iter), 0);
    check("midrst_d", 32'(done), 0);
    tick();
    check("midrst_hold_i", 32'(cur_iter), 0);
    check("midrst_hold_d", 32'(done), 0);
    jumped = 1'b0;
    reset  = 1'b1;
    #1;
    check("midrst_rel_d", 32'(done), 0);

    // Independent loop, count 12 step 4
    load(18'd12, 1'b1);
    check("ind12_d0", 32'(done), 0);
    jump_n(1);
    check("ind12_i4", 32'(cur_iter), 4);
    check("ind12_d4", 32'(done), 0);
    jump_n(1);
    check("ind12_i8", 32'(cur_iter), 8);
    check("ind12_d8", 32'(done), 1);
    jump_n(2);
    check("ind12_sat", 32'(cur_iter), 8);

    // Non-multiple trip count, 13 step 4
    load(18'd13, 1'b1);
    jump_n(2);
    check("ind13_i8", 32'(cur_iter), 8);
    check("ind13_d8", 32'(done), 0);
    jump_n(1);
    check("ind13_i12", 32'(cur_iter), 12);
    check("ind13_d12", 32'(done), 1);
    jump_n(1);
    check("ind13_sat", 32'(cur_iter), 12);

    // Single-pass loops
    load(18'd0, 1'b0);
    check("cnt0_m0_d", 32'(done), 1);
    load(18'd1, 1'b0);
    check("cnt1_m0_d", 32'(done), 1);
    load(18'd0, 1'b1);
    check("cnt0_m1_d", 32'(done), 1);
    load(18'd1, 1'b1);
    check("cnt1_m1_d", 32'(done), 1);
    jump_n(1);
    check("cnt1_m1_i", 32'(cur_iter), 0);

    // Gating, plus configuration changes ignored while running
    load(18'd3, 1'b0);
    should_increment = 1'b0;
    init_count = 18'd1;
    init_indep = 1'b1;
    jump_n(5);
    check("gate_i", 32'(cur_iter), 0);
    check("gate_d", 32'(done), 0);
    should_increment = 1'b1;
    jump_n(1);
    check("cfg_ign_i", 32'(cur_iter), 1);
    check("cfg_ign_d", 32'(done), 0);

    // Full-width count is not truncated
    load(18'h3FFFF, 1'b0);
    check("wide_d0", 32'(done), 0);
    jump_n(4);
    check("wide_i4", 32'(cur_iter), 4);
    check("wide_d4", 32'(done), 0);

    // Narrow instance: limit at the top of the range, step 1
    w_load(4'd15, 1'b0);
    check("w15_d0", 32'(w_done), 0);
    w_jump_n(13);
    check("w15_i13", 32'(w_cur_iter), 13);
    check("w15_d13", 32'(w_done), 0);
    w_jump_n(1);
    check("w15_i14", 32'(w_cur_iter), 14);
    check("w15_d14", 32'(w_done), 1);
    w_jump_n(2);
    check("w15_sat", 32'(w_cur_iter), 14);

    // Narrow instance: step 4 where iter+step overflows the index width
    w_load(4'd15, 1'b1);
    w_jump_n(2);
    check("w15s4_i8", 32'(w_cur_iter), 8);
    check("w15s4_d8", 32'(w_done), 0);
    w_jump_n(1);
    check("w15s4_i12", 32'(w_cur_iter), 12);
    check("w15s4_d12", 32'(w_done), 1);
    w_jump_n(2);
    check("w15s4_sat", 32'(w_cur_iter), 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
